// File: rtl/cnn_pkg.sv
// Shared types and default widths for the convolution datapath.
// Holds the window sequencer state encoding.
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;
  localparam int CNN_DIM_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/col_skid_buf.sv
// One-entry skid for a window column {pad, row0, row1, row2}.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module col_skid_buf
  import cnn_pkg::*;
#(
  parameter int WIDTH = 3 * CNN_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             full_q;
  logic [WIDTH-1:0] hold_q;

  // A held entry always wins over fresh data.
  assign in_ready  = !full_q;
  assign out_valid = full_q || in_valid;
  assign out_data  = full_q ? hold_q : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else if (full_q) begin
      if (out_ready) full_q <= 1'b0;
    end else if (in_valid && !out_ready) begin
      full_q <= 1'b1;
      hold_q <= in_data;
    end
  end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Raster sequencer for the 3x3 activation window: issues line-buffer reads,
// zero-pads lanes, loads the window and hands patches to the PE array.
// Ports: start/img_w/img_h, rd_en/rd_row/rd_col, mem_row0..2, act_load,
// data_*_row, patch_valid/patch_row/patch_col/out_ready, busy, done.
module conv3x3_window_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int DIM_WIDTH  = CNN_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  img_w,
  input  logic [DIM_WIDTH-1:0]  img_h,
  output logic                  rd_en,
  output logic [DIM_WIDTH-1:0]  rd_row,
  output logic [DIM_WIDTH-1:0]  rd_col,
  input  logic [DATA_WIDTH-1:0] mem_row0,
  input  logic [DATA_WIDTH-1:0] mem_row1,
  input  logic [DATA_WIDTH-1:0] mem_row2,
  output logic                  act_load,
  output logic [DATA_WIDTH-1:0] data_first_row,
  output logic [DATA_WIDTH-1:0] data_second_row,
  output logic [DATA_WIDTH-1:0] data_third_row,
  output logic                  patch_valid,
  output logic [DIM_WIDTH-1:0]  patch_row,
  output logic [DIM_WIDTH-1:0]  patch_col,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = 3 * DATA_WIDTH + 1;
  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH:0]   TWO = (DIM_WIDTH + 1)'(2);
  localparam logic [DATA_WIDTH-1:0] ZW = '0;

  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0] w_q, h_q;
  logic [DIM_WIDTH-1:0] iss_row, ld_row;
  logic [DIM_WIDTH:0]   iss_slot, ld_cnt;
  logic [DIM_WIDTH:0]   last_slot;
  logic [DIM_WIDTH-1:0] prow_q, pcol_q;
  logic                 pv_q, done_q;

  logic inf_valid, inf_pad, inf_z0, inf_z2;
  logic [CW-1:0] arr_col, cur_col;
  logic skid_ready, col_avail;
  logic issue, iss_pad, last_issue;
  logic start_ok, final_hs, lane_zero;

  assign last_slot = {1'b0, w_q} + 1'b1;
  assign iss_pad   = (iss_slot == '0) || (iss_slot == last_slot);

  // Row padding is applied on arrival; slot padding travels as a flag.
  assign arr_col = {inf_pad,
                    inf_z0 ? ZW : mem_row0,
                    mem_row1,
                    inf_z2 ? ZW : mem_row2};

  col_skid_buf #(
    .WIDTH(CW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inf_valid),
    .in_ready (skid_ready),
    .in_data  (arr_col),
    .out_valid(col_avail),
    .out_ready(act_load),
    .out_data (cur_col)
  );

  assign act_load = col_avail && (!pv_q || out_ready);

  // An arrival that cannot load takes the skid, so stop issuing.
  assign issue = (state_q == RUN) && skid_ready
              && !(inf_valid && !act_load);

  assign last_issue = issue && (iss_slot == last_slot)
                   && (iss_row == h_q - ONE);

  assign rd_en  = issue && !iss_pad;
  assign rd_row = rd_en ? iss_row : '0;
  assign rd_col = rd_en ? DIM_WIDTH'(iss_slot - 1'b1) : '0;

  assign lane_zero       = !act_load || cur_col[CW-1];
  assign data_first_row  = lane_zero ? ZW : cur_col[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign data_second_row = lane_zero ? ZW : cur_col[2*DATA_WIDTH-1:DATA_WIDTH];
  assign data_third_row  = lane_zero ? ZW : cur_col[DATA_WIDTH-1:0];

  assign start_ok = (state_q == IDLE) && start && !done_q;

  // In DRAIN an empty pipeline means the visible patch is the last one.
  assign final_hs = (state_q == DRAIN) && pv_q && out_ready && !col_avail;

  assign patch_valid = pv_q;
  assign patch_row   = prow_q;
  assign patch_col   = pcol_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (final_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= '0;
      h_q      <= '0;
      iss_slot <= '0;
      iss_row  <= '0;
    end else if (start_ok) begin
      w_q      <= img_w;
      h_q      <= img_h;
      iss_slot <= '0;
      iss_row  <= '0;
    end else if (issue) begin
      if (iss_slot == last_slot) begin
        iss_slot <= '0;
        iss_row  <= iss_row + ONE;
      end else begin
        iss_slot <= iss_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inf_valid <= 1'b0;
      inf_pad   <= 1'b0;
      inf_z0    <= 1'b0;
      inf_z2    <= 1'b0;
    end else begin
      inf_valid <= issue;
      inf_pad   <= iss_pad;
      inf_z0    <= (iss_row == '0);
      inf_z2    <= (iss_row == h_q - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      ld_row <= '0;
    end else if (start_ok) begin
      ld_cnt <= '0;
      ld_row <= '0;
    end else if (act_load) begin
      if (ld_cnt == last_slot) begin
        ld_cnt <= '0;
        ld_row <= ld_row + ONE;
      end else begin
        ld_cnt <= ld_cnt + 1'b1;
      end
    end
  end

  // Third and later loads of a row complete a patch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      prow_q <= '0;
      pcol_q <= '0;
    end else if (act_load && (ld_cnt >= TWO)) begin
      pv_q   <= 1'b1;
      prow_q <= ld_row;
      pcol_q <= DIM_WIDTH'(ld_cnt - TWO);
    end else if (pv_q && out_ready) begin
      pv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Directed bench for conv3x3_window_ctrl with a line-buffer model
// and a shadow 3x3 window register file.
module tb_conv3x3_window_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  img_w, img_h;
  logic        rd_en;
  logic [7:0]  rd_row, rd_col;
  logic [15:0] mem_row0, mem_row1, mem_row2;
  logic        act_load;
  logic [15:0] d0, d1, d2;
  logic        patch_valid;
  logic [7:0]  patch_row, patch_col;
  logic        out_ready;
  logic        busy, done;

  conv3x3_window_ctrl #(
    .DATA_WIDTH(16),
    .DIM_WIDTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .img_w          (img_w),
    .img_h          (img_h),
    .rd_en          (rd_en),
    .rd_row         (rd_row),
    .rd_col         (rd_col),
    .mem_row0       (mem_row0),
    .mem_row1       (mem_row1),
    .mem_row2       (mem_row2),
    .act_load       (act_load),
    .data_first_row (d0),
    .data_second_row(d1),
    .data_third_row (d2),
    .patch_valid    (patch_valid),
    .patch_row      (patch_row),
    .patch_col      (patch_col),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, cur_w, cur_h, base, rdy_mode, stall_left;
  int exp_r, exp_c, npatch, done_cnt, done_cyc, first_pv;
  bit hit12, prev_pv, prev_rdy, prev_rd;
  logic [7:0]  prev_prow, prev_pcol;
  logic [15:0] win [3][3];

  // Line buffer: data one cycle after rd_en; junk otherwise and
  // outside the tile so that missing zeroing is visible.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      mem_row0 <= (rd_row == 8'd0) ? 16'hDEAD :
        16'(base + (int'(rd_row) - 1) * 16 + int'(rd_col));
      mem_row1 <= 16'(base + int'(rd_row) * 16 + int'(rd_col));
      mem_row2 <= (int'(rd_row) + 1 >= cur_h) ? 16'hBEEF :
        16'(base + (int'(rd_row) + 1) * 16 + int'(rd_col));
    end else begin
      mem_row0 <= 16'hA5A5;
      mem_row1 <= 16'hA5A5;
      mem_row2 <= 16'hA5A5;
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ev(int r, int c);
    if (r < 0 || r >= cur_h || c < 0 || c >= cur_w) return 16'h0;
    return 16'(base + r * 16 + c);
  endfunction

  function automatic logic [143:0] win_flat();
    logic [143:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[127:0], win[j][i]};
    return v;
  endfunction

  function automatic logic [143:0] exp_flat(int pr, int pc);
    logic [143:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[127:0], ev(pr - 1 + i, pc - 1 + j)};
    return v;
  endfunction

  function automatic logic [84:0] outs_all();
    return {rd_en, rd_row, rd_col, act_load, d0, d1, d2,
            patch_valid, patch_row, patch_col, busy, done};
  endfunction

  task automatic monitor();
    logic [143:0] p00;
    p00 = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1,
           16'h0, 16'h10, 16'h11};
    if (rd_en) begin
      chk("rd_col_range", 160'(int'(rd_col) < cur_w), 160'(1));
      chk("rd_row_range", 160'(int'(rd_row) < cur_h), 160'(1));
      chk("rd_skid_full", 160'(prev_rd && !act_load), 160'(0));
    end
    if (prev_pv && !prev_rdy)
      chk("patch_hold", {patch_valid, patch_row, patch_col},
          {1'b1, prev_prow, prev_pcol});
    if (patch_valid && !out_ready)
      chk("stall_no_load", 160'(act_load), 160'(0));
    if (patch_valid && first_pv < 0) first_pv = cyc;
    if (patch_valid && patch_row == 8'd1 && patch_col == 8'd2)
      hit12 = 1'b1;
    if (patch_valid && out_ready) begin
      chk("patch_idx", {patch_row, patch_col},
          {8'(exp_r), 8'(exp_c)});
      chk("patch_data", win_flat(), exp_flat(exp_r, exp_c));
      if (cur_w == 4 && base == 0 && exp_r == 0 && exp_c == 0)
        chk("patch00", win_flat(), p00);
      if (exp_r == cur_h - 1 && exp_c == cur_w - 1)
        chk("edge_zero", {win[0][2], win[1][2], win[2][2],
                          win[2][0], win[2][1]}, 160'(0));
      npatch++;
      exp_c++;
      if (exp_c == cur_w) begin
        exp_c = 0;
        exp_r++;
      end
    end
    if (act_load) begin
      win[0] = win[1];
      win[1] = win[2];
      win[2][0] = d0;
      win[2][1] = d1;
      win[2][2] = d2;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_pv   = patch_valid;
    prev_rdy  = out_ready;
    prev_prow = patch_row;
    prev_pcol = patch_col;
    prev_rd   = rd_en;
  endtask

  task automatic step(input logic st);
    @(posedge clk);
    cyc++;
    #1;
    start = st;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 9) < 3);
      default: begin
        if (npatch >= 5 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 9) < 3);
        end
      end
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic run_tile(input int w, input int h, input int mode,
                          input int inj, input bit stop12,
                          input int exp_done, input int exp_first);
    img_w = 8'(w);
    img_h = 8'(h);
    cur_w = w;
    cur_h = h;
    rdy_mode = mode;
    stall_left = 10;
    exp_r = 0;
    exp_c = 0;
    npatch = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_pv = -1;
    hit12 = 1'b0;
    prev_pv = 1'b0;
    prev_rd = 1'b0;
    cyc = -1;
    step(1'b1);
    step(1'b0);
    img_w = 8'd2;
    img_h = 8'd2;
    while (done_cnt == 0 && cyc < 400 && !(stop12 && hit12))
      step(1'(cyc + 1 == inj));
    if (!stop12) begin
      repeat (3) step(1'b0);
      chk("patch_count", 160'(npatch), 160'(w * h));
      chk("done_once", 160'(done_cnt), 160'(1));
      chk("idle_busy", 160'(busy), 160'(0));
      if (exp_done >= 0)
        chk("done_cycle", 160'(done_cyc), 160'(exp_done));
      if (exp_first >= 0)
        chk("first_patch", 160'(first_pv), 160'(exp_first));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    img_w = 8'd0;
    img_h = 8'd0;
    base = 0;
    cur_w = 1;
    cur_h = 1;
    rdy_mode = 0;
    cyc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win[i][j] = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 160'(outs_all()), 160'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 4x3 tile, always ready, stray start at cycle 8
    base = 0;
    run_tile(4, 3, 0, 8, 1'b0, 21, 5);

    // Same tile under random backpressure plus a long stall
    run_tile(4, 3, 2, -1, 1'b0, -1, -1);

    // 1x1 tile, start pulsed in the done cycle
    base = 'h100;
    run_tile(1, 1, 0, 6, 1'b0, 6, 5);

    // Abort with reset while patch (1,2) is presented
    base = 0;
    run_tile(4, 3, 0, -1, 1'b1, -1, -1);
    chk("hit_p12", 160'(hit12), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 160'(outs_all()), 160'(0));
    repeat (3) step(1'b0);
    chk("abort_no_done", 160'(done_cnt), 160'(0));
    chk("abort_outs_hold", 160'(outs_all()), 160'(0));
    rst_n = 1'b1;

    // Fresh 2x2 tile after the abort
    base = 'h40;
    run_tile(2, 2, 0, -1, 1'b0, 11, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
